mem_stage_ctrl: RTL and testbench
=================================

// Module: mem_stage_ctrl
// PURPOSE
//  Memory-stage controller: the consumer end of the EX/MEM pipeline register.
//  Takes the EX/MEM outputs (opcode, rd, ALU result, store data) and runs loads and stores to data memory.
//  Memory uses a req/ack handshake with variable latency; the block stalls EX/MEM until each access finishes.
//  Drives the MEM/WB inputs: one registered writeback beat per retired instruction.
// PARAMETERS
//  ADDR_W   10     word-address width to data memory
//  OP_NOP   5'd0   bubble opcode, no writeback
//  OP_LDR   5'd12  load: rd <= mem[alu]
//  OP_STR   5'd13  store: mem[alu] <= store data
//  OP_BR    5'd7   branch, no register writeback
//  TIMEOUT  16     max BUSY cycles without ack before abort (>=2)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  ex_valid     in   1       EX/MEM holds a valid instruction
//  ex_opcode    in   5       OpCodeOut of EX/MEM
//  ex_rd        in   9       RdOutOut of EX/MEM
//  ex_alu       in   32      AluResultOut: byte address (mem ops) or result
//  ex_sdata     in   32      store data
//  stall_out    out  1       hold EX/MEM (combinational)
//  mem_req      out  1       memory request
//  mem_we       out  1       1 = write, 0 = read
//  mem_addr     out  ADDR_W  word address = ex_alu[ADDR_W+1:2]
//  mem_wdata    out  32      write data
//  mem_ack      in   1       memory completes; mem_rdata valid in the same cycle
//  mem_rdata    in   32      read data
//  wb_valid     out  1       one-cycle writeback beat to MEM/WB
//  wb_opcode    out  5       retired opcode
//  wb_rd        out  9       destination register
//  wb_data      out  32      ALU result or load data
//  wb_we        out  1       register-file write enable
//  mem_err      out  1       sticky: access timed out
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; timeout counter=0; every registered output=0.
//    A request in flight is dropped immediately. mem_err clears only on reset.
//  - FSM states: IDLE, BUSY.
//  - IDLE, ex_valid=0: next cycle wb_valid=0. No stall.
//  - IDLE, valid non-memory op: next cycle wb_valid=1; wb_data=ex_alu; wb_rd/wb_opcode copied.
//    wb_we=1 unless opcode is OP_NOP, OP_BR or OP_STR. Latency 1, no stall.
//  - IDLE, valid OP_LDR/OP_STR:
//    - stall_out=1 in the same cycle.
//    - On the edge: latch addr, wdata, we, rd, opcode; mem_req=1; go to BUSY; counter=0.
//  - BUSY:
//    - mem_req, mem_we, mem_addr, mem_wdata are held stable. stall_out = !mem_ack && !timeout_hit.
//    - Ack cycle: stall_out=0, so EX/MEM advances on this edge. Next cycle: mem_req=0, state=IDLE, wb_valid=1.
//      Load: wb_data=mem_rdata, wb_we=1. Store: wb_data=latched address, wb_we=0.
//    - No ack: counter increments each cycle. timeout_hit = (counter == TIMEOUT-1).
//      On timeout: stall_out=0; next cycle mem_req=0, mem_err=1, wb_valid=1, wb_we=0, state=IDLE.
//    - Ack and timeout in the same cycle: ack wins, normal completion.
//  - mem_ack while in IDLE is ignored.
//  - Back-to-back memory ops: the second enters IDLE->BUSY on the cycle after wb_valid. mem_req has at least 1 low cycle between requests.
//  - wb_valid is never high for two cycles for the same instruction. Outputs other than wb_valid hold their last value.
//  - Memory-op latency = 2 + wait cycles (wait = cycles between req and ack).
// TESTING
//  1 ALU op, opcode=3, rd=8, alu=2 -> next cycle wb_valid=1, wb_rd=8, wb_data=2, wb_we=1; stall_out never set.
//  2 OP_LDR, alu=32'h40, memory acks after 3 cycles with rdata=32'hCAFE -> mem_addr=10'h10;
//    stall high 3 cycles; then wb_data=32'hCAFE, wb_we=1.
//  3 OP_STR, alu=32'h08, sdata=9, ack on first cycle -> mem_we=1, mem_wdata=9, mem_addr=2; wb_we=0; total 2 cycles.
//  4 OP_LDR with no ack -> req held 16 cycles, then mem_err=1, wb_we=0, stall released; a following ALU op still retires.
//  5 LDR then STR back-to-back, each acked after 1 cycle -> two req pulses separated by 1 low cycle;
//    wb beats in order LDR then STR.
//  6 rst_n low mid-BUSY -> mem_req, stall_out, wb_valid, mem_err drop at once; after release a new op completes normally.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: consumes EX/MEM, runs req/ack loads and stores to data memory,
// stalls EX/MEM while an access is outstanding, and emits one registered MEM/WB beat per instruction.
module mem_stage_ctrl #(
  parameter int          ADDR_W  = 10,
  parameter logic [4:0]  OP_NOP  = 5'd0,
  parameter logic [4:0]  OP_LDR  = 5'd12,
  parameter logic [4:0]  OP_STR  = 5'd13,
  parameter logic [4:0]  OP_BR   = 5'd7,
  parameter int          TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [4:0]        ex_opcode,
  input  logic [8:0]        ex_rd,
  input  logic [31:0]       ex_alu,
  input  logic [31:0]       ex_sdata,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_opcode,
  output logic [8:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_we,
  output logic              mem_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      lat_alu;
  logic [8:0]       lat_rd;
  logic [4:0]       lat_op;
  logic             is_mem;
  logic             timeout_hit;
  logic             stall;

  always_comb begin
    is_mem      = ex_valid && (ex_opcode == OP_LDR || ex_opcode == OP_STR);
    timeout_hit = (state == BUSY) && (cnt == CNT_W'(TIMEOUT - 1));
    stall       = 1'b0;
    if (state == IDLE) stall = is_mem;
    else               stall = !mem_ack && !timeout_hit;
    // Gated by rst_n so the stall drops the moment reset asserts, even with a memory op held.
    stall_out   = rst_n && stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_opcode <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      wb_we     <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (is_mem) begin
            state     <= BUSY;
            cnt       <= '0;
            mem_req   <= 1'b1;
            mem_we    <= (ex_opcode == OP_STR);
            mem_addr  <= ex_alu[ADDR_W+1:2];
            mem_wdata <= ex_sdata;
          end else if (ex_valid) begin
            wb_valid  <= 1'b1;
            wb_data   <= ex_alu;
            wb_rd     <= ex_rd;
            wb_opcode <= ex_opcode;
            wb_we     <= !(ex_opcode == OP_NOP || ex_opcode == OP_BR || ex_opcode == OP_STR);
          end
        end
        BUSY: begin
          // Ack has priority over a coincident timeout.
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            wb_valid  <= 1'b1;
            wb_rd     <= lat_rd;
            wb_opcode <= lat_op;
            wb_we     <= !mem_we;
            wb_data   <= mem_we ? lat_alu : mem_rdata;
          end else if (timeout_hit) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_err   <= 1'b1;
            wb_valid  <= 1'b1;
            wb_rd     <= lat_rd;
            wb_opcode <= lat_op;
            wb_we     <= 1'b0;
            wb_data   <= lat_alu;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Instruction fields needed at retirement; EX/MEM has moved on by then only after the ack edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && is_mem) begin
      lat_alu <= ex_alu;
      lat_rd  <= ex_rd;
      lat_op  <= ex_opcode;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, reset-in-flight sequence,
// and randomized instructions checked against a transaction-level model.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_opcode;
  logic [8:0]  ex_rd;
  logic [31:0] ex_alu;
  logic [31:0] ex_sdata;
  logic        stall_out;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_opcode;
  logic [8:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        mem_err;

  mem_stage_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_alu(ex_alu), .ex_sdata(ex_sdata), .stall_out(stall_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_opcode(wb_opcode), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_we(wb_we), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [4:0]  op;
    logic [8:0]  rd;
    logic [31:0] alu;
    logic [31:0] sdata;
    int          k;       // BUSY cycle on which memory acks; >16 means never
    logic [31:0] rdata;
    bit          spur;    // stray ack while no request is outstanding
    int          e_stall;
    bit          e_wbv;
    logic [31:0] e_data;
    bit          e_we;
    bit          e_err;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit valid, logic [4:0] op, logic [8:0] rd, logic [31:0] alu,
                              logic [31:0] sdata, int k, logic [31:0] rdata, int e_stall,
                              bit e_wbv, logic [31:0] e_data, bit e_we, bit e_err);
    vec_t v;
    v.valid = valid; v.op = op; v.rd = rd; v.alu = alu; v.sdata = sdata; v.k = k;
    v.rdata = rdata; v.spur = 1'b0; v.e_stall = e_stall; v.e_wbv = e_wbv;
    v.e_data = e_data; v.e_we = e_we; v.e_err = e_err;
    return v;
  endfunction

  // Transaction-level reference: what one instruction costs and what it retires with.
  function automatic vec_t predict(bit valid, logic [4:0] op, logic [8:0] rd, logic [31:0] alu,
                                   logic [31:0] sdata, int k, logic [31:0] rdata, bit spur,
                                   inout bit err);
    vec_t v;
    bit is_mem, is_ld, to;
    is_mem = valid && (op == 5'd12 || op == 5'd13);
    is_ld  = valid && op == 5'd12;
    to     = is_mem && k > 16;
    v.valid = valid; v.op = op; v.rd = rd; v.alu = alu; v.sdata = sdata;
    v.k = k; v.rdata = rdata; v.spur = spur;
    v.e_stall = !is_mem ? 0 : (to ? 16 : k);
    v.e_wbv   = valid;
    v.e_data  = (is_ld && !to) ? rdata : alu;
    if (!valid || to)  v.e_we = 1'b0;
    else if (is_ld)    v.e_we = 1'b1;
    else               v.e_we = !(op == 5'd0 || op == 5'd7 || op == 5'd13);
    err = err || to;
    v.e_err = err;
    return v;
  endfunction

  // Present one instruction from the negedge, act as memory, then check its writeback beat.
  task automatic apply(input vec_t v, input string tag);
    int  stalls = 0;
    int  reqs   = 0;
    int  cyc    = 0;
    bit  first  = 1'b1;
    bit  adv    = 1'b0;
    bit  is_mem;
    is_mem    = v.valid && (v.op == 5'd12 || v.op == 5'd13);
    ex_valid  = v.valid;
    ex_opcode = v.op;
    ex_rd     = v.rd;
    ex_alu    = v.alu;
    ex_sdata  = v.sdata;
    while (!adv && cyc < 40) begin
      if (mem_req) begin
        reqs++;
        if (first) begin
          chk({tag, " mem_addr"},  {22'd0, mem_addr}, {22'd0, v.alu[11:2]});
          chk({tag, " mem_we"},    {31'd0, mem_we}, {31'd0, (v.op == 5'd13)});
          if (v.op == 5'd13) chk({tag, " mem_wdata"}, mem_wdata, v.sdata);
          first = 1'b0;
        end
        mem_ack   = (reqs == v.k);
        mem_rdata = v.rdata;
      end else begin
        mem_ack   = v.spur;
        mem_rdata = 32'hDEAD_BEEF;
      end
      #1;
      if (stall_out) stalls++;
      else adv = 1'b1;
      @(negedge clk);
      cyc++;
    end
    mem_ack = 1'b0;
    if (!adv) begin
      n_vec++; n_err++;
      $display("FAIL %s stall_stuck: stall_out still high after %0d cycles", tag, cyc);
    end
    chk({tag, " stall_cycles"}, stalls, v.e_stall);
    chk({tag, " req_cycles"},   reqs, is_mem ? v.e_stall : 0);
    chk({tag, " wb_valid"},     {31'd0, wb_valid}, {31'd0, v.e_wbv});
    if (v.e_wbv) begin
      chk({tag, " wb_data"},   wb_data, v.e_data);
      chk({tag, " wb_we"},     {31'd0, wb_we}, {31'd0, v.e_we});
      chk({tag, " wb_rd"},     {23'd0, wb_rd}, {23'd0, v.rd});
      chk({tag, " wb_opcode"}, {27'd0, wb_opcode}, {27'd0, v.op});
    end
    chk({tag, " mem_req_low"}, {31'd0, mem_req}, 32'd0);
    chk({tag, " mem_err"},     {31'd0, mem_err}, {31'd0, v.e_err});
  endtask

  vec_t tbl[11];
  bit   err_m;

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_rd = '0; ex_alu = '0; ex_sdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst wb_valid",  {31'd0, wb_valid}, 32'd0);
    chk("rst mem_req",   {31'd0, mem_req}, 32'd0);
    chk("rst mem_err",   {31'd0, mem_err}, 32'd0);
    chk("rst wb_data",   wb_data, 32'd0);
    chk("rst mem_addr",  {22'd0, mem_addr}, 32'd0);
    chk("rst stall_out", {31'd0, stall_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //          valid op     rd     alu           sdata  k   rdata          stl wbv data          we err
    tbl[0]  = mk(1, 5'd3,  9'd8,  32'h2,        0,     0,  0,             0,  1,  32'h2,        1, 0);
    tbl[1]  = mk(1, 5'd12, 9'd5,  32'h40,       0,     3,  32'hCAFE,      3,  1,  32'hCAFE,     1, 0);
    tbl[2]  = mk(1, 5'd13, 9'd6,  32'h08,       9,     1,  0,             1,  1,  32'h08,       0, 0);
    tbl[3]  = mk(1, 5'd0,  9'd1,  32'h55,       0,     0,  0,             0,  1,  32'h55,       0, 0);
    tbl[4]  = mk(1, 5'd7,  9'd2,  32'h1000,     0,     0,  0,             0,  1,  32'h1000,     0, 0);
    tbl[5]  = mk(0, 5'd3,  9'd3,  32'h99,       0,     0,  0,             0,  0,  32'h0,        0, 0);
    tbl[6]  = mk(1, 5'd12, 9'd10, 32'h100,      0,     1,  32'h1234,      1,  1,  32'h1234,     1, 0);
    tbl[7]  = mk(1, 5'd13, 9'd11, 32'h104,      32'h77, 1, 0,             1,  1,  32'h104,      0, 0);
    tbl[8]  = mk(1, 5'd12, 9'd12, 32'h200,      0,     99, 0,             16, 1,  32'h200,      0, 1);
    tbl[9]  = mk(1, 5'd4,  9'd9,  32'h77,       0,     0,  0,             0,  1,  32'h77,       1, 1);
    tbl[10] = mk(1, 5'd12, 9'd13, 32'hFFC,      0,     16, 32'h5A5A,      16, 1,  32'h5A5A,     1, 1);
    for (int i = 0; i < 11; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset while a load is outstanding: everything drops at once, then a store completes.
    ex_valid = 1'b1; ex_opcode = 5'd12; ex_rd = 9'd20; ex_alu = 32'h300; ex_sdata = '0;
    repeat (3) @(negedge clk);
    chk("busy mem_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst mem_req",   {31'd0, mem_req}, 32'd0);
    chk("midrst stall_out", {31'd0, stall_out}, 32'd0);
    chk("midrst wb_valid",  {31'd0, wb_valid}, 32'd0);
    chk("midrst mem_err",   {31'd0, mem_err}, 32'd0);
    ex_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    err_m = 1'b0;
    apply(predict(1, 5'd13, 9'd21, 32'h10, 32'hABCD, 2, 0, 0, err_m), "post_rst");

    for (int i = 0; i < 250; i++) begin
      logic [4:0] op;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: op = 5'd0;
        1: op = 5'd7;
        2, 3: op = 5'd12;
        4: op = 5'd13;
        default: op = 5'($urandom);
      endcase
      apply(predict($urandom_range(0, 7) != 0, op, 9'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 9) == 0) ? 17 : $urandom_range(1, 16), $urandom,
                    1'($urandom), err_m), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
